bsg_gateway_bringup_seq: RTL and testbench

//  Power-up/link bring-up sequencer for the gateway FPGA. Enables ASIC rails in

---
 rtl/bsg_gateway_bringup_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_bsg_gateway_bringup_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_gateway_bringup_seq.sv
// Gateway bring-up sequencer: ordered rail power-up, tag release, link
// reset with bounded calibration retries, and reverse-order power-down.
module bsg_gateway_bringup_seq #(
  parameter int settle_cycles_p = 1024,
  parameter int reset_hold_p    = 64,
  parameter int calib_timeout_p = 65536,
  parameter int max_retries_p   = 3,
  localparam int rw_lp = (max_retries_p > 0)
                       ? $clog2(max_retries_p + 1) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             tag_done_i,
  input  logic             calib_done_i,
  output logic             io_en_o,
  output logic             core_en_o,
  output logic             pll_en_o,
  output logic             tag_reset_o,
  output logic             link_reset_o,
  output logic             ready_o,
  output logic             error_o,
  output logic [rw_lp-1:0] retries_o,
  output logic [2:0]       state_o
);

  localparam int max_sh_lp = (settle_cycles_p > reset_hold_p)
                           ? settle_cycles_p : reset_hold_p;
  localparam int max_lp = (max_sh_lp > calib_timeout_p)
                        ? max_sh_lp : calib_timeout_p;
  localparam int cw_lp = $clog2(max_lp + 1);

  localparam logic [cw_lp-1:0] settle_ld_lp = cw_lp'(settle_cycles_p - 1);
  localparam logic [cw_lp-1:0] hold_ld_lp   = cw_lp'(reset_hold_p - 1);
  localparam logic [cw_lp-1:0] calib_ld_lp  = cw_lp'(calib_timeout_p - 1);
  localparam logic [rw_lp-1:0] max_r_lp     = rw_lp'(max_retries_p);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IO_UP   = 3'd1,
    CORE_UP = 3'd2,
    PLL_UP  = 3'd3,
    TAG     = 3'd4,
    LINK    = 3'd5,
    RUN     = 3'd6,
    FAIL    = 3'd7
  } state_e;

  // Power-down runs inside IDLE so state_o reads 0 throughout.
  typedef enum logic [1:0] {
    DN_NONE = 2'd0,
    DN_CORE = 2'd1,
    DN_IO   = 2'd2
  } down_e;

  state_e           state_q, state_d;
  down_e            down_q, down_d;
  logic             wait_q, wait_d;
  logic [cw_lp-1:0] cnt_q, cnt_d;
  logic             io_q, io_d;
  logic             core_q, core_d;
  logic             pll_q, pll_d;
  logic             tag_q, tag_d;
  logic             link_q, link_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [rw_lp-1:0] retries_q, retries_d;
  logic             timeout;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    down_d    = down_q;
    wait_d    = wait_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - cw_lp'(1);
    io_d      = io_q;
    core_d    = core_q;
    pll_d     = pll_q;
    tag_d     = tag_q;
    link_d    = link_q;
    ready_d   = ready_q;
    err_d     = err_q;
    retries_d = retries_q;
    timeout   = 1'b0;

    if (!start_i && state_q != IDLE) begin
      state_d = IDLE;
      down_d  = core_q ? DN_CORE : DN_IO;
      wait_d  = 1'b0;
      cnt_d   = settle_ld_lp;
      pll_d   = 1'b0;
      ready_d = 1'b0;
      err_d   = 1'b0;
      link_d  = 1'b1;
      tag_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (down_q == DN_CORE) begin
            if (cnt_zero) begin
              core_d = 1'b0;
              down_d = DN_IO;
              cnt_d  = settle_ld_lp;
            end
          end else if (down_q == DN_IO) begin
            if (cnt_zero) begin
              io_d   = 1'b0;
              down_d = DN_NONE;
            end
          end else if (start_i && !io_q && !core_q && !pll_q) begin
            state_d   = IO_UP;
            io_d      = 1'b1;
            retries_d = '0;
            cnt_d     = settle_ld_lp;
          end
        end
        IO_UP: begin
          if (cnt_zero) begin
            state_d = CORE_UP;
            core_d  = 1'b1;
            cnt_d   = settle_ld_lp;
          end
        end
        CORE_UP: begin
          if (cnt_zero) begin
            state_d = PLL_UP;
            pll_d   = 1'b1;
            cnt_d   = settle_ld_lp;
          end
        end
        PLL_UP: begin
          if (cnt_zero) begin
            state_d = TAG;
            tag_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        TAG: begin
          if (tag_done_i) begin
            state_d = LINK;
            wait_d  = 1'b0;
            link_d  = 1'b1;
            cnt_d   = hold_ld_lp;
          end
        end
        LINK: begin
          if (!wait_q) begin
            if (cnt_zero) begin
              wait_d = 1'b1;
              link_d = 1'b0;
              cnt_d  = calib_ld_lp;
            end
          end else if (calib_done_i) begin
            state_d = RUN;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_zero) begin
            timeout = 1'b1;
          end
        end
        RUN: begin
          if (!calib_done_i) timeout = 1'b1;
        end
        FAIL: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (timeout) begin
        ready_d = 1'b0;
        link_d  = 1'b1;
        wait_d  = 1'b0;
        if (retries_q < max_r_lp) begin
          retries_d = retries_q + rw_lp'(1);
          state_d   = LINK;
          cnt_d     = hold_ld_lp;
        end else begin
          state_d = FAIL;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      down_q    <= DN_NONE;
      wait_q    <= 1'b0;
      cnt_q     <= '0;
      io_q      <= 1'b0;
      core_q    <= 1'b0;
      pll_q     <= 1'b0;
      tag_q     <= 1'b1;
      link_q    <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      down_q    <= down_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      io_q      <= io_d;
      core_q    <= core_d;
      pll_q     <= pll_d;
      tag_q     <= tag_d;
      link_q    <= link_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      retries_q <= retries_d;
    end
  end

  assign io_en_o      = io_q;
  assign core_en_o    = core_q;
  assign pll_en_o     = pll_q;
  assign tag_reset_o  = tag_q;
  assign link_reset_o = link_q;
  assign ready_o      = ready_q;
  assign error_o      = err_q;
  assign retries_o    = retries_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_bsg_gateway_bringup_seq.sv
// Bench for bsg_gateway_bringup_seq: vector table, corner-case sequences,
// and random stimulus against a deadline-based reference model.
module tb_bsg_gateway_bringup_seq;

  localparam int S = 4;
  localparam int H = 2;
  localparam int T = 10;
  localparam int R = 1;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       tag_done_i = 1'b0;
  logic       calib_done_i = 1'b0;
  logic       io_en_o, core_en_o, pll_en_o;
  logic       tag_reset_o, link_reset_o;
  logic       ready_o, error_o;
  logic [0:0] retries_o;
  logic [2:0] state_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  bsg_gateway_bringup_seq #(
    .settle_cycles_p(S),
    .reset_hold_p(H),
    .calib_timeout_p(T),
    .max_retries_p(R)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .start_i(start_i),
    .tag_done_i(tag_done_i),
    .calib_done_i(calib_done_i),
    .io_en_o(io_en_o),
    .core_en_o(core_en_o),
    .pll_en_o(pll_en_o),
    .tag_reset_o(tag_reset_o),
    .link_reset_o(link_reset_o),
    .ready_o(ready_o),
    .error_o(error_o),
    .retries_o(retries_o),
    .state_o(state_o)
  );

  // {io,core,pll,tag_rst,link_rst,ready,error,retries,state}
  function automatic logic [10:0] ex(input int io, input int co,
                                     input int pl, input int tr,
                                     input int lr, input int rd,
                                     input int er, input int rt,
                                     input int st);
    return {1'(io), 1'(co), 1'(pl), 1'(tr), 1'(lr),
            1'(rd), 1'(er), 1'(rt), 3'(st)};
  endfunction

  function automatic logic [10:0] got();
    return {io_en_o, core_en_o, pll_en_o, tag_reset_o, link_reset_o,
            ready_o, error_o, retries_o, state_o};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] g;
    g = got();
    total_cnt++;
    if (g === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, g, exp);
  endtask

  task automatic tick(input logic s, input logic t, input logic c);
    start_i      = s;
    tag_done_i   = t;
    calib_done_i = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    start_i      = 1'b0;
    tag_done_i   = 1'b0;
    calib_done_i = 1'b0;
    reset_i      = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  logic [10:0] rst_v;

  task automatic bring_to_link();
    do_reset();
    check("reset", rst_v);
    repeat (13) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("link_entry", ex(1,1,1,0,1,0,0,0,5));
  endtask

  // Reference model: phases with absolute-cycle deadlines.
  localparam int P_IDLE = 0, P_IO = 1, P_CORE = 2, P_PLL = 3, P_TAG = 4;
  localparam int P_HOLD = 5, P_WAIT = 6, P_RUN = 7, P_FAIL = 8;
  localparam int P_DCORE = 9, P_DIO = 10;

  int m_ph, m_due, m_cyc, m_tries;
  int m_io, m_core, m_pll, m_tr, m_lr, m_rdy, m_err;

  task automatic model_reset();
    m_ph = P_IDLE; m_due = 0; m_cyc = 0; m_tries = 0;
    m_io = 0; m_core = 0; m_pll = 0;
    m_tr = 1; m_lr = 1; m_rdy = 0; m_err = 0;
  endtask

  task automatic model_timeout(input int nc);
    m_rdy = 0;
    m_lr  = 1;
    if (m_tries < R) begin
      m_tries++;
      m_ph  = P_HOLD;
      m_due = nc + H;
    end else begin
      m_ph  = P_FAIL;
      m_err = 1;
    end
  endtask

  task automatic model_step(input logic s, input logic t,
                            input logic c);
    int nc;
    int up;
    nc = m_cyc + 1;
    up = (m_ph >= P_IO && m_ph <= P_FAIL) ? 1 : 0;
    if (!s && up != 0) begin
      m_pll = 0; m_rdy = 0; m_err = 0; m_lr = 1; m_tr = 1;
      m_ph  = (m_core != 0) ? P_DCORE : P_DIO;
      m_due = nc + S;
    end else begin
      case (m_ph)
        P_IDLE:
          if (s && m_io == 0 && m_core == 0 && m_pll == 0) begin
            m_ph = P_IO; m_io = 1; m_tries = 0; m_due = nc + S;
          end
        P_IO:
          if (nc == m_due) begin
            m_ph = P_CORE; m_core = 1; m_due = nc + S;
          end
        P_CORE:
          if (nc == m_due) begin
            m_ph = P_PLL; m_pll = 1; m_due = nc + S;
          end
        P_PLL:
          if (nc == m_due) begin
            m_ph = P_TAG; m_tr = 0;
          end
        P_TAG:
          if (t) begin
            m_ph = P_HOLD; m_lr = 1; m_due = nc + H;
          end
        P_HOLD:
          if (nc == m_due) begin
            m_ph = P_WAIT; m_lr = 0; m_due = nc + T;
          end
        P_WAIT:
          if (c) begin
            m_ph = P_RUN; m_rdy = 1;
          end else if (nc == m_due) model_timeout(nc);
        P_RUN:
          if (!c) model_timeout(nc);
        P_DCORE:
          if (nc == m_due) begin
            m_core = 0; m_ph = P_DIO; m_due = nc + S;
          end
        P_DIO:
          if (nc == m_due) begin
            m_io = 0; m_ph = P_IDLE;
          end
        default: ;
      endcase
    end
    m_cyc = nc;
  endtask

  function automatic int st_of(input int ph);
    if (ph >= P_IO && ph <= P_TAG) return ph;
    if (ph == P_HOLD || ph == P_WAIT) return 5;
    if (ph == P_RUN) return 6;
    if (ph == P_FAIL) return 7;
    return 0;
  endfunction

  typedef struct {
    int n;
    int s;
    int t;
    int c;
    logic [10:0] e;
  } vec_t;

  vec_t v[$];

  initial begin
    logic s, t, c;
    rst_v = ex(0,0,0,1,1,0,0,0,0);

    v.push_back('{1, 1, 0, 0, ex(1,0,0,1,1,0,0,0,1)});
    v.push_back('{3, 1, 0, 0, ex(1,0,0,1,1,0,0,0,1)});
    v.push_back('{1, 1, 0, 0, ex(1,1,0,1,1,0,0,0,2)});
    v.push_back('{4, 1, 0, 0, ex(1,1,1,1,1,0,0,0,3)});
    v.push_back('{4, 1, 0, 0, ex(1,1,1,0,1,0,0,0,4)});
    v.push_back('{7, 1, 0, 0, ex(1,1,1,0,1,0,0,0,4)});
    v.push_back('{1, 1, 1, 0, ex(1,1,1,0,1,0,0,0,5)});
    v.push_back('{1, 1, 0, 0, ex(1,1,1,0,1,0,0,0,5)});
    v.push_back('{1, 1, 0, 0, ex(1,1,1,0,0,0,0,0,5)});
    v.push_back('{5, 1, 0, 0, ex(1,1,1,0,0,0,0,0,5)});
    v.push_back('{1, 1, 0, 1, ex(1,1,1,0,0,1,0,0,6)});
    v.push_back('{3, 1, 0, 1, ex(1,1,1,0,0,1,0,0,6)});
    v.push_back('{1, 1, 0, 0, ex(1,1,1,0,1,0,0,1,5)});
    v.push_back('{2, 1, 0, 0, ex(1,1,1,0,0,0,0,1,5)});
    v.push_back('{1, 1, 0, 1, ex(1,1,1,0,0,1,0,1,6)});
    v.push_back('{1, 0, 0, 1, ex(1,1,0,1,1,0,0,1,0)});
    v.push_back('{3, 1, 0, 0, ex(1,1,0,1,1,0,0,1,0)});
    v.push_back('{1, 0, 0, 0, ex(1,0,0,1,1,0,0,1,0)});
    v.push_back('{3, 1, 0, 0, ex(1,0,0,1,1,0,0,1,0)});
    v.push_back('{1, 0, 0, 0, ex(0,0,0,1,1,0,0,1,0)});

    do_reset();
    check("reset", rst_v);
    foreach (v[i]) begin
      for (int k = 0; k < v[i].n; k++)
        tick(1'(v[i].s), 1'(v[i].t), 1'(v[i].c));
      check($sformatf("vec%0d", i), v[i].e);
    end

    // calib on the timeout cycle wins, then exhaust from RUN
    bring_to_link();
    repeat (11) tick(1'b1, 1'b0, 1'b0);
    check("pre_timeout", ex(1,1,1,0,0,0,0,0,5));
    tick(1'b1, 1'b0, 1'b1);
    check("collide_run", ex(1,1,1,0,0,1,0,0,6));
    tick(1'b1, 1'b0, 1'b0);
    check("run_drop", ex(1,1,1,0,1,0,0,1,5));
    repeat (11) tick(1'b1, 1'b0, 1'b0);
    check("retry_wait", ex(1,1,1,0,0,0,0,1,5));
    tick(1'b1, 1'b0, 1'b0);
    check("fail", ex(1,1,1,0,1,0,1,1,7));
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    check("fail_hold", ex(1,1,1,0,1,0,1,1,7));
    tick(1'b0, 1'b0, 1'b0);
    check("fail_down", ex(1,1,0,1,1,0,0,1,0));

    // shutdown beats success on the timeout cycle
    bring_to_link();
    repeat (11) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("collide_down", ex(1,1,0,1,1,0,0,0,0));

    // calib never arrives
    bring_to_link();
    repeat (12) tick(1'b1, 1'b0, 1'b0);
    check("timeout1", ex(1,1,1,0,1,0,0,1,5));
    tick(1'b1, 1'b0, 1'b0);
    check("repulse", ex(1,1,1,0,1,0,0,1,5));
    tick(1'b1, 1'b0, 1'b0);
    check("relink", ex(1,1,1,0,0,0,0,1,5));
    repeat (10) tick(1'b1, 1'b0, 1'b0);
    check("exhaust", ex(1,1,1,0,1,0,1,1,7));

    // async reset mid CORE_UP
    do_reset();
    repeat (6) tick(1'b1, 1'b0, 1'b0);
    check("core_up", ex(1,1,0,1,1,0,0,0,2));
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst", rst_v);

    // random stimulus vs model
    do_reset();
    model_reset();
    s = 1'b1;
    t = 1'b0;
    c = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      check($sformatf("rand%0d", i),
            ex(m_io, m_core, m_pll, m_tr, m_lr, m_rdy, m_err,
               m_tries, st_of(m_ph)));
      if (s) s = ($urandom_range(0, 249) != 0);
      else s = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) c = ~c;
      model_step(s, t, c);
      tick(s, t, c);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
